bp_update_sched: RTL and testbench

//  Update scheduler for the local branch predictor tables (LHT history, LPT 2-bit counters).

---
 rtl/bp_pkg.sv | 24 ++
 rtl/bp_update_sched_if.sv | 14 +
 rtl/bp_upd_fifo.sv | 50 +++++
 rtl/bp_update_sched.sv | 138 +++++++++++++
 tb/tb_bp_update_sched.sv | 363 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// Shared constants, counter encodings and helpers for the local branch predictor
// update scheduler.
package bp_pkg;

  localparam int unsigned DEF_LHT_IDX  = 12;
  localparam int unsigned DEF_LPT_IDX  = 10;
  localparam int unsigned DEF_HIST_LEN = 10;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef enum logic {StInit, StRun} bp_state_e;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == CTR_ST) ? CTR_ST : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
  endfunction

endpackage

// File: rtl/bp_update_sched_if.sv
// Resolved-branch update channel from EX into the predictor update scheduler.
interface bp_update_sched_if #(
  parameter int unsigned HIST_LEN = bp_pkg::DEF_HIST_LEN
);
  logic                valid;
  logic                ready;
  logic [31:0]         pc;
  logic                taken;
  logic [HIST_LEN-1:0] hist;
  logic [1:0]          ctr;

  modport master (output valid, pc, taken, hist, ctr, input ready);
  modport slave  (input valid, pc, taken, hist, ctr, output ready);
endinterface

// File: rtl/bp_upd_fifo.sv
// Synchronous FIFO holding pending predictor updates; flush empties it in one cycle,
// and push+pop together is legal even when full.
module bp_upd_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_flush,
  input  logic                             i_push,
  input  logic [WIDTH-1:0]                 i_data,
  input  logic                             i_pop,
  output logic [WIDTH-1:0]                 o_head,
  output logic                             o_empty,
  output logic                             o_full,
  output logic [$clog2(DEPTH+1)-1:0]       o_count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + PTR_W'(1);
      if (i_pop)  r_rptr <= r_rptr + PTR_W'(1);
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wptr] <= i_data;
  end

  assign o_head  = r_mem[r_rptr];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_count = r_count;
endmodule

// File: rtl/bp_update_sched.sv
// Local predictor update scheduler: initialises LHT/LPT after reset or clear, then
// drains queued branch resolutions into one table write per cycle.
module bp_update_sched
  import bp_pkg::*;
#(
  parameter int unsigned LHT_IDX    = DEF_LHT_IDX,
  parameter int unsigned LPT_IDX    = DEF_LPT_IDX,
  parameter int unsigned HIST_LEN   = DEF_HIST_LEN,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_clear,
  bp_update_sched_if.slave    upd,
  input  logic                i_port_busy,
  output logic                o_fetch_stall,
  output logic                o_lht_we,
  output logic [LHT_IDX-1:0]  o_lht_idx,
  output logic [HIST_LEN-1:0] o_lht_wdata,
  output logic                o_lpt_we,
  output logic [LPT_IDX-1:0]  o_lpt_idx,
  output logic [1:0]          o_lpt_wdata,
  output logic                o_init_done
);
  localparam int unsigned ENT_W = LHT_IDX + 1 + HIST_LEN + 2;
  localparam int unsigned ST_W  = $clog2(STARVE_MAX + 1);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [LHT_IDX-1:0] K_LAST     = '1;
  localparam logic [ST_W-1:0]    STARVE_LIM = ST_W'(STARVE_MAX);

  bp_state_e          r_state, w_state_nxt;
  logic [LHT_IDX-1:0] r_k, w_k_nxt;
  logic [ST_W-1:0]    r_starve, w_starve_nxt;

  logic                w_pop, w_flush, w_push, w_empty, w_full, w_k_in_lpt, w_unused;
  logic [ENT_W-1:0]    w_head;
  logic [CNT_W-1:0]    w_count;
  logic [LHT_IDX-1:0]  w_head_pcs;
  logic                w_head_taken;
  logic [HIST_LEN-1:0] w_head_hist;
  logic [1:0]          w_head_ctr;

  // Misaligned PCs are accepted but never enqueued, so they produce no write.
  assign w_push = upd.valid && upd.ready && (upd.pc[1:0] == 2'b00);
  assign upd.ready = (r_state == StRun) && (!w_full || w_pop);

  bp_upd_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_data  ({upd.pc[LHT_IDX+1:2], upd.taken, upd.hist, upd.ctr}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (w_count)
  );

  assign {w_head_pcs, w_head_taken, w_head_hist, w_head_ctr} = w_head;
  assign w_k_in_lpt = (LHT_IDX <= LPT_IDX) || ((r_k >> LPT_IDX) == '0);
  assign w_unused   = ^{upd.pc[31:LHT_IDX+2], w_head_hist[HIST_LEN-1], w_count};

  always_comb begin
    w_state_nxt   = r_state;
    w_k_nxt       = r_k;
    w_starve_nxt  = r_starve;
    w_pop         = 1'b0;
    w_flush       = 1'b0;
    o_fetch_stall = 1'b0;
    o_init_done   = 1'b0;
    o_lht_we      = 1'b0;
    o_lht_idx     = '0;
    o_lht_wdata   = '0;
    o_lpt_we      = 1'b0;
    o_lpt_idx     = '0;
    o_lpt_wdata   = '0;
    unique case (r_state)
      StInit: begin
        o_lht_we    = 1'b1;
        o_lht_idx   = r_k;
        o_lpt_we    = w_k_in_lpt;
        o_lpt_idx   = r_k[LPT_IDX-1:0];
        o_lpt_wdata = CTR_WNT;
        if (i_clear) begin
          w_k_nxt = '0;
        end else if (r_k == K_LAST) begin
          w_k_nxt     = '0;
          w_state_nxt = StRun;
        end else begin
          w_k_nxt = r_k + LHT_IDX'(1);
        end
      end
      StRun: begin
        o_init_done = 1'b1;
        if (i_clear) begin
          w_flush      = 1'b1;
          w_starve_nxt = '0;
          w_state_nxt  = StInit;
        end else if (w_empty) begin
          w_starve_nxt = '0;
        end else begin
          w_pop = !i_port_busy || (r_starve == STARVE_LIM);
          if (w_pop) begin
            w_starve_nxt  = '0;
            o_fetch_stall = i_port_busy;
            o_lht_we      = 1'b1;
            o_lht_idx     = w_head_pcs;
            o_lht_wdata   = {w_head_hist[HIST_LEN-2:0], w_head_taken};
            o_lpt_we      = 1'b1;
            // LPT index uses the history as it was at predict time.
            o_lpt_idx     = w_head_pcs[LPT_IDX-1:0] ^ w_head_hist[LPT_IDX-1:0];
            o_lpt_wdata   = w_head_taken ? sat_inc(w_head_ctr) : sat_dec(w_head_ctr);
          end else begin
            w_starve_nxt = r_starve + ST_W'(1);
          end
        end
      end
      default: w_state_nxt = StInit;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StInit;
      r_k      <= '0;
      r_starve <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_k      <= w_k_nxt;
      r_starve <= w_starve_nxt;
    end
  end
endmodule

// File: tb/tb_bp_update_sched.sv
// Self-checking bench for bp_update_sched: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model.
module tb_bp_update_sched;
  logic        clk = 1'b0;
  logic        rst, i_clear, i_port_busy;
  logic        o_fetch_stall, o_lht_we, o_lpt_we, o_init_done;
  logic [11:0] o_lht_idx;
  logic [9:0]  o_lht_wdata, o_lpt_idx;
  logic [1:0]  o_lpt_wdata;

  bp_update_sched_if upd_if ();

  bp_update_sched dut (
    .clk           (clk),
    .rst           (rst),
    .i_clear       (i_clear),
    .upd           (upd_if),
    .i_port_busy   (i_port_busy),
    .o_fetch_stall (o_fetch_stall),
    .o_lht_we      (o_lht_we),
    .o_lht_idx     (o_lht_idx),
    .o_lht_wdata   (o_lht_wdata),
    .o_lpt_we      (o_lpt_we),
    .o_lpt_idx     (o_lpt_idx),
    .o_lpt_wdata   (o_lpt_wdata),
    .o_init_done   (o_init_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] pc;
    bit          t;
    logic [9:0]  h;
    logic [1:0]  c;
  } ent_t;

  typedef struct packed {
    logic        ready;
    logic        stall;
    logic        done;
    logic        lht_we;
    logic [11:0] lht_idx;
    logic [9:0]  lht_wdata;
    logic        lpt_we;
    logic [9:0]  lpt_idx;
    logic [1:0]  lpt_wdata;
  } outs_t;

  // Behavioural model: pending updates, init sweep position, starvation count.
  ent_t mq[$];
  bit   m_run;
  int   m_k;
  int   m_starve;

  function automatic bit model_pop();
    return m_run && !i_clear && (mq.size() > 0) && (!i_port_busy || m_starve == 8);
  endfunction

  function automatic outs_t model_outs();
    outs_t o = '0;
    ent_t  e;
    if (!m_run) begin
      o.lht_we    = 1'b1;
      o.lht_idx   = m_k[11:0];
      o.lpt_we    = (m_k < 1024);
      o.lpt_idx   = m_k[9:0];
      o.lpt_wdata = 2'b01;
    end else begin
      o.done  = 1'b1;
      o.ready = (mq.size() < 4) || model_pop();
      o.stall = model_pop() && i_port_busy;
      if (model_pop()) begin
        e           = mq[0];
        o.lht_we    = 1'b1;
        o.lht_idx   = 12'(e.pc >> 2);
        o.lht_wdata = 10'({e.h, e.t});
        o.lpt_we    = 1'b1;
        o.lpt_idx   = 10'(e.pc >> 2) ^ e.h;
        if (e.t) o.lpt_wdata = (e.c == 2'd3) ? 2'd3 : e.c + 2'd1;
        else     o.lpt_wdata = (e.c == 2'd0) ? 2'd0 : e.c - 2'd1;
      end
    end
    if (!o.lht_we) begin o.lht_idx = '0; o.lht_wdata = '0; end
    if (!o.lpt_we) begin o.lpt_idx = '0; o.lpt_wdata = '0; end
    return o;
  endfunction

  function automatic outs_t dut_outs();
    outs_t o;
    o.ready     = upd_if.ready;
    o.stall     = o_fetch_stall;
    o.done      = o_init_done;
    o.lht_we    = o_lht_we;
    o.lht_idx   = o_lht_we ? o_lht_idx : '0;
    o.lht_wdata = o_lht_we ? o_lht_wdata : '0;
    o.lpt_we    = o_lpt_we;
    o.lpt_idx   = o_lpt_we ? o_lpt_idx : '0;
    o.lpt_wdata = o_lpt_we ? o_lpt_wdata : '0;
    return o;
  endfunction

  // Advance the model with the inputs currently applied, then move past the next edge.
  task automatic step();
    bit   pop = model_pop();
    bit   acc = upd_if.valid && model_outs().ready;
    ent_t e;
    if (rst) begin
      mq.delete(); m_run = 0; m_k = 0; m_starve = 0;
    end else if (!m_run) begin
      if (i_clear) m_k = 0;
      else if (m_k == 4095) begin m_run = 1; m_k = 0; end
      else m_k++;
    end else if (i_clear) begin
      mq.delete(); m_run = 0; m_k = 0; m_starve = 0;
    end else begin
      if (pop) begin mq.delete(0); m_starve = 0; end
      else if (mq.size() == 0) m_starve = 0;
      else if (i_port_busy) m_starve++;
      if (acc && upd_if.pc[1:0] == 2'b00) begin
        e.pc = upd_if.pc; e.t = upd_if.taken; e.h = upd_if.hist; e.c = upd_if.ctr;
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    upd_if.valid = 1'b0; i_port_busy = 1'b0; i_clear = 1'b0;
  endtask

  task automatic set_upd(input logic [31:0] pc, input bit t, input logic [9:0] h,
                         input logic [1:0] c);
    upd_if.valid = 1'b1; upd_if.pc = pc; upd_if.taken = t; upd_if.hist = h; upd_if.ctr = c;
  endtask

  task automatic test_reset();
    outs_t a, e;
    rst = 1'b1; idle(); set_upd(32'h0, 0, '0, '0); upd_if.valid = 1'b0;
    step();
    rst = 1'b0;
    #1;
    n_checks++;
    if (upd_if.ready !== 1'b0 || o_fetch_stall !== 1'b0 || o_init_done !== 1'b0 ||
        o_lht_we !== 1'b1 || o_lpt_we !== 1'b1 || o_lht_idx !== 12'd0 || o_lpt_idx !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_first_cycle: got rdy=%b stl=%b done=%b lwe=%b pwe=%b li=%h pi=%h, want 0 0 0 1 1 0 0",
               upd_if.ready, o_fetch_stall, o_init_done, o_lht_we, o_lpt_we, o_lht_idx, o_lpt_idx);
    end
    for (int i = 0; i < 4096; i++) begin
      a = dut_outs(); e = model_outs();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL init_sweep k=%0d: got %h expected %h", i, a, e);
      end
      step();
    end
    #1;
    n_checks++;
    if (o_init_done !== 1'b1 || o_lht_we !== 1'b0) begin
      n_fail++;
      $display("FAIL init_done_4097: got done=%b lht_we=%b, want 1 0", o_init_done, o_lht_we);
    end
  endtask

  task automatic test_update();
    idle(); set_upd(32'h104, 1, 10'h3, 2'b01);
    #1;
    n_checks++;
    if (o_lht_we !== 1'b0) begin
      n_fail++; $display("FAIL update_push_cycle: got lht_we=%b want 0", o_lht_we);
    end
    step();
    idle();
    #1;
    n_checks++;
    if (o_lht_we !== 1'b1 || o_lht_idx !== 12'h041 || o_lht_wdata !== 10'h007 ||
        o_lpt_we !== 1'b1 || o_lpt_idx !== 10'h042 || o_lpt_wdata !== 2'b10 || o_fetch_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL update_write: got we=%b/%b li=%h lw=%h pi=%h pw=%b, want 1/1 041 007 042 10",
               o_lht_we, o_lpt_we, o_lht_idx, o_lht_wdata, o_lpt_idx, o_lpt_wdata);
    end
    step();
  endtask

  task automatic test_saturation();
    logic [1:0] cin  [2] = '{2'b11, 2'b00};
    bit         tin  [2] = '{1'b1, 1'b0};
    logic [1:0] want [2] = '{2'b11, 2'b00};
    for (int i = 0; i < 2; i++) begin
      idle(); set_upd(32'h200, tin[i], 10'h0, cin[i]);
      #1; step();
      idle();
      #1;
      n_checks++;
      if (o_lpt_we !== 1'b1 || o_lpt_wdata !== want[i]) begin
        n_fail++;
        $display("FAIL saturation_%0d: got we=%b wdata=%b want 1 %b", i, o_lpt_we, o_lpt_wdata, want[i]);
      end
      step();
    end
  endtask

  task automatic test_starvation();
    bit         exp_stall;
    logic [11:0] exp_idx;
    idle(); i_port_busy = 1'b1; set_upd(32'h10, 0, '0, 2'b01);
    #1; step();
    set_upd(32'h20, 1, '0, 2'b01);
    for (int i = 1; i <= 20; i++) begin
      if (i >= 2) upd_if.valid = 1'b0;
      #1;
      exp_stall = (i == 9) || (i == 18);
      exp_idx   = (i == 9) ? 12'h004 : 12'h008;
      n_checks++;
      if (o_fetch_stall !== exp_stall || o_lht_we !== exp_stall ||
          (exp_stall && o_lht_idx !== exp_idx)) begin
        n_fail++;
        $display("FAIL starvation_cycle_%0d: got stall=%b we=%b idx=%h want %b %b %h",
                 i, o_fetch_stall, o_lht_we, o_lht_idx, exp_stall, exp_stall, exp_idx);
      end
      step();
    end
    idle();
  endtask

  task automatic test_full();
    logic [31:0] pcs [5] = '{32'h40, 32'h44, 32'h48, 32'h4C, 32'h50};
    int          n = 0;
    bit          exp_rdy;
    idle(); i_port_busy = 1'b1;
    for (int i = 0; i <= 9; i++) begin
      if (n < 5) set_upd(pcs[n], 1, '0, 2'b01); else upd_if.valid = 1'b0;
      #1;
      exp_rdy = (i < 4) || (i == 9);
      n_checks++;
      if (upd_if.ready !== exp_rdy || o_fetch_stall !== (i == 9) ||
          (i == 9 && o_lht_idx !== 12'h010)) begin
        n_fail++;
        $display("FAIL full_cycle_%0d: got rdy=%b stall=%b idx=%h want %b %b 010",
                 i, upd_if.ready, o_fetch_stall, o_lht_idx, exp_rdy, (i == 9));
      end
      if (upd_if.valid && upd_if.ready) n++;
      step();
    end
    idle();
    for (int j = 1; j <= 5; j++) begin
      #1;
      n_checks++;
      if (j < 5 && (o_lht_we !== 1'b1 || o_lht_idx !== 12'(pcs[j] >> 2))) begin
        n_fail++;
        $display("FAIL full_order_%0d: got we=%b idx=%h want 1 %h", j, o_lht_we, o_lht_idx,
                 12'(pcs[j] >> 2));
      end else if (j == 5 && o_lht_we !== 1'b0) begin
        n_fail++;
        $display("FAIL full_drained: got we=%b want 0", o_lht_we);
      end
      step();
    end
  endtask

  task automatic test_clear();
    idle(); i_port_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_upd(32'h60 + 32'(4 * i), 0, '0, 2'b10);
      #1; step();
    end
    upd_if.valid = 1'b0; i_clear = 1'b1;
    #1;
    n_checks++;
    if (o_lht_we !== 1'b0 || o_lpt_we !== 1'b0) begin
      n_fail++; $display("FAIL clear_no_write: got we=%b/%b want 0/0", o_lht_we, o_lpt_we);
    end
    step();
    idle();
    #1;
    n_checks++;
    if (o_init_done !== 1'b0 || o_lht_we !== 1'b1 || o_lht_idx !== 12'd0) begin
      n_fail++;
      $display("FAIL clear_init_start: got done=%b we=%b idx=%h want 0 1 000",
               o_init_done, o_lht_we, o_lht_idx);
    end
    for (int i = 0; i < 100; i++) step();
    i_clear = 1'b1;
    #1; step();
    i_clear = 1'b0;
    #1;
    n_checks++;
    if (o_lht_idx !== 12'd0 || o_init_done !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_restart: got idx=%h done=%b want 000 0", o_lht_idx, o_init_done);
    end
    for (int i = 0; i < 4095; i++) step();
    n_checks++;
    if (o_init_done !== 1'b0 || o_lht_idx !== 12'hFFF) begin
      n_fail++;
      $display("FAIL clear_last_init: got done=%b idx=%h want 0 fff", o_init_done, o_lht_idx);
    end
    step();
    set_upd(32'h102, 1, 10'h1, 2'b01);
    #1;
    n_checks++;
    if (o_init_done !== 1'b1 || upd_if.ready !== 1'b1 || o_lht_we !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_run_again: got done=%b rdy=%b we=%b want 1 1 0",
               o_init_done, upd_if.ready, o_lht_we);
    end
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (o_lht_we !== 1'b0 || o_lpt_we !== 1'b0) begin
        n_fail++;
        $display("FAIL misaligned_no_write_%0d: got we=%b/%b want 0/0", i, o_lht_we, o_lpt_we);
      end
      step();
    end
  endtask

  task automatic test_random();
    outs_t       a, e;
    logic [31:0] pc;
    for (int i = 0; i < 600; i++) begin
      pc = $urandom;
      if ($urandom_range(7) != 0) pc[1:0] = 2'b00;
      if ($urandom_range(3) == 0) pc = 32'h0000_0abc;
      set_upd(pc, 1'($urandom), 10'($urandom), 2'($urandom));
      upd_if.valid = 1'($urandom);
      i_port_busy  = ($urandom_range(3) != 0);
      i_clear      = 1'b0;
      #1;
      a = dut_outs(); e = model_outs();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL random_cycle_%0d: got %h expected %h", i, a, e);
      end
      step();
    end
    idle();
  endtask

  initial begin
    idle(); rst = 1'b1;
    upd_if.pc = '0; upd_if.taken = 1'b0; upd_if.hist = '0; upd_if.ctr = '0;
    @(posedge clk); #1;
    test_reset();
    test_update();
    test_saturation();
    test_starvation();
    test_full();
    test_random();
    test_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
